// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press/release/long-press/auto-repeat pulses.
// Latency: k_lvl/k_prs/k_rel follow a stable key_n change by 2+CN clk cycles; k_lng LN after k_prs; k_rpt every RN after k_lng.
// Backpressure: none; every output is a registered level or single-cycle pulse, with no handshake.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   key_n  - raw button, active-low, asynchronous to clk
//   k_lvl  - debounced level (1 = pressed)
//   k_prs  - one-cycle pulse on debounced press
//   k_rel  - one-cycle pulse on debounced release
//   k_lng  - one-cycle pulse once the press has been held LN cycles
//   k_rpt  - one-cycle auto-repeat pulse every RN cycles after k_lng
module key_conditioner #(
    parameter int CN = 240000,
    parameter int LN = 24000000,
    parameter int RN = 4800000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic k_lvl,
    output logic k_prs,
    output logic k_rel,
    output logic k_lng,
    output logic k_rpt
);

    localparam int DW = $clog2(CN + 1);
    localparam int HW = $clog2(LN + 1);
    localparam int RW = $clog2(RN + 1);

    typedef enum logic [1:0] {
        REL = 2'd0,
        PRS = 2'd1,
        HLD = 2'd2
    } state_t;

    // Synchronizer resets to the released level so a key held through
    // reset release is seen as a fresh press.
    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_cnt_d;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_d;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_d;
    state_t        state;
    state_t        state_d;
    logic          lvl_d;
    logic          prs_d;
    logic          rel_d;
    logic          lng_d;
    logic          rpt_d;

    logic differs;
    logic tog;

    // The counter holds the number of consecutive differing samples seen
    // so far; the edge that would make it CN is the toggle edge itself.
    assign differs = (~s2) != k_lvl;
    assign tog     = differs && (deb_cnt == DW'(CN - 1));

    always_comb begin
        deb_cnt_d  = differs ? deb_cnt + 1'b1 : '0;
        lvl_d      = k_lvl;
        state_d    = state;
        hold_cnt_d = hold_cnt;
        rpt_cnt_d  = rpt_cnt;
        prs_d      = 1'b0;
        rel_d      = 1'b0;
        lng_d      = 1'b0;
        rpt_d      = 1'b0;

        if (tog) begin
            deb_cnt_d = '0;
            lvl_d     = ~k_lvl;
        end

        // A debounced release is checked first in PRS/HLD so it wins over a
        // k_lng or k_rpt falling due on the same edge.
        unique case (state)
            REL: begin
                if (tog) begin
                    state_d    = PRS;
                    hold_cnt_d = '0;
                    prs_d      = 1'b1;
                end
            end
            PRS: begin
                if (tog) begin
                    state_d = REL;
                    rel_d   = 1'b1;
                end else if (hold_cnt == HW'(LN - 1)) begin
                    state_d    = HLD;
                    hold_cnt_d = '0;
                    rpt_cnt_d  = '0;
                    lng_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            HLD: begin
                if (tog) begin
                    state_d = REL;
                    rel_d   = 1'b1;
                end else if (rpt_cnt == RW'(RN - 1)) begin
                    rpt_cnt_d = '0;
                    rpt_d     = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt + 1'b1;
                end
            end
            default: begin
                state_d = REL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt  <= '0;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
            state    <= REL;
            k_lvl    <= 1'b0;
            k_prs    <= 1'b0;
            k_rel    <= 1'b0;
            k_lng    <= 1'b0;
            k_rpt    <= 1'b0;
        end else begin
            deb_cnt  <= deb_cnt_d;
            hold_cnt <= hold_cnt_d;
            rpt_cnt  <= rpt_cnt_d;
            state    <= state_d;
            k_lvl    <= lvl_d;
            k_prs    <= prs_d;
            k_rel    <= rel_d;
            k_lng    <= lng_d;
            k_rpt    <= rpt_d;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: directed button scenarios plus randomized key waveforms.
// Outputs are compared every cycle against a timestamp-based reference model.
// Model: toggle when the last CN synchronized samples since the previous toggle all show the new level.
module tb_key_conditioner;

    localparam int CN   = 4;
    localparam int LN   = 16;
    localparam int RN   = 8;
    localparam int NMAX = 8192;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic key_n = 1'b1;
    logic k_lvl;
    logic k_prs;
    logic k_rel;
    logic k_lng;
    logic k_rpt;

    key_conditioner #(.CN(CN), .LN(LN), .RN(RN)) dut (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .k_lvl (k_lvl),
        .k_prs (k_prs),
        .k_rel (k_rel),
        .k_lng (k_lng),
        .k_rpt (k_rpt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state, indexed by absolute clock edge number.
    bit         raw [NMAX];
    int         t          = 0;
    int         rst_edge   = 0;
    int         last_tog   = 0;
    int         press_edge = 0;
    bit         mlvl       = 1'b0;
    logic [4:0] exp_o      = '0;

    // Scenario log: cycle numbers relative to rc = 0.
    int rc     = 0;
    int prs_at = -1;
    int rel_at = -1;
    int lng_at = -1;
    int nlng   = 0;
    int nrel   = 0;
    int rpt_q[$];

    function automatic bit samp(input int e);
        if (e < 1 || e <= rst_edge || e >= NMAX) return 1'b1;
        return raw[e];
    endfunction

    task automatic model_edge();
        bit tog;
        bit prs;
        bit rel;
        bit lng;
        bit rpt;
        int d;
        if (!rst) begin
            rst_edge = t;
            last_tog = t;
            mlvl     = 1'b0;
            exp_o    = '0;
            return;
        end
        // The synchronized sample used at edge e is the raw sample of edge e-2.
        tog = (t - CN >= last_tog);
        for (int k = 0; k < CN; k++)
            if ((samp(t - k - 2) == 1'b0) == mlvl) tog = 1'b0;
        prs = tog && !mlvl;
        rel = tog && mlvl;
        lng = 1'b0;
        rpt = 1'b0;
        if (!tog && mlvl) begin
            d   = t - press_edge;
            lng = (d == LN);
            rpt = (d > LN) && (((d - LN) % RN) == 0);
        end
        if (tog) begin
            mlvl     = !mlvl;
            last_tog = t;
            if (mlvl) press_edge = t;
        end
        exp_o = {mlvl, prs, rel, lng, rpt};
    endtask

    task automatic clear_log();
        rc     = 0;
        prs_at = -1;
        rel_at = -1;
        lng_at = -1;
        nlng   = 0;
        nrel   = 0;
        rpt_q.delete();
    endtask

    task automatic step(input bit kn);
        key_n = kn;
        @(posedge clk);
        t++;
        if (t < NMAX) raw[t] = kn;
        model_edge();
        #1;
        chk("outs", 32'({k_lvl, k_prs, k_rel, k_lng, k_rpt}), 32'(exp_o));
        rc++;
        if (k_prs) prs_at = rc;
        if (k_rel) begin rel_at = rc; nrel++; end
        if (k_lng) begin lng_at = rc; nlng++; end
        if (k_rpt) rpt_q.push_back(rc);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1);
    endtask

    initial begin
        #1;
        chk("reset_state", 32'({k_lvl, k_prs, k_rel, k_lng, k_rpt}), 32'd0);
        repeat (3) step(1'b1);
        rst = 1'b1;
        idle(10);

        // Clean press and release.
        clear_log();
        repeat (10) step(1'b0);
        chk("press_cycle", 32'(prs_at), 32'd6);
        chk("press_lvl", 32'(k_lvl), 32'd1);
        clear_log();
        repeat (10) step(1'b1);
        chk("release_cycle", 32'(rel_at), 32'd6);
        chk("release_lvl", 32'(k_lvl), 32'd0);

        // Glitch shorter than CN.
        clear_log();
        repeat (3) step(1'b0);
        idle(10);
        chk("glitch_pulses", 32'(prs_at + rel_at + lng_at + rpt_q.size()), 32'(-3));
        chk("glitch_lvl", 32'(k_lvl), 32'd0);

        // Long hold with auto-repeat.
        clear_log();
        repeat (60) step(1'b0);
        idle(15);
        chk("long_prs", 32'(prs_at), 32'd6);
        chk("long_lng", 32'(lng_at), 32'd22);
        chk("long_nrpt", 32'(rpt_q.size()), 32'd5);
        if (rpt_q.size() == 5) begin
            for (int i = 0; i < 5; i++)
                chk("long_rpt_at", 32'(rpt_q[i]), 32'(30 + 8 * i));
        end
        chk("long_rel", 32'(rel_at), 32'd66);

        // Short hold: k_rel at k_prs + 10.
        clear_log();
        repeat (10) step(1'b0);
        idle(15);
        chk("short_gap", 32'(rel_at - prs_at), 32'd10);
        chk("short_nlng", 32'(nlng + rpt_q.size()), 32'd0);

        // Release colliding with a due k_lng.
        clear_log();
        repeat (16) step(1'b0);
        idle(15);
        chk("coll_rel", 32'(rel_at), 32'd22);
        chk("coll_nlng", 32'(nlng), 32'd0);
        // Back in REL: a new press must produce k_prs.
        clear_log();
        repeat (8) step(1'b0);
        chk("coll_repress", 32'(prs_at), 32'd6);
        idle(15);

        // Reset asserted during HLD, key still held through release.
        clear_log();
        repeat (40) step(1'b0);
        chk("hld_lvl", 32'(k_lvl), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_drop", 32'({k_lvl, k_prs, k_rel, k_lng, k_rpt}), 32'd0);
        repeat (3) step(1'b0);
        rst = 1'b1;
        clear_log();
        repeat (10) step(1'b0);
        chk("rst_repress", 32'(prs_at), 32'd6);
        chk("rst_norel", 32'(nrel), 32'd0);
        idle(15);

        // Randomized key waveforms, with occasional resets.
        for (int s = 0; s < 80; s++) begin
            bit lv;
            int len;
            lv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                              : int'($urandom_range(1, 8));
            repeat (len) step(lv);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                #1;
                chk("rnd_rst_drop", 32'({k_lvl, k_prs, k_rel, k_lng, k_rpt}), 32'd0);
                repeat (2) step(lv);
                rst = 1'b1;
            end
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
